// File: rtl/status_pkg.sv
// Status codes, vending FSM encodings and UART transmitter states.
// Define STATUS_TX_PARITY_EN to add an even-parity bit to every frame.
package status_pkg;

    typedef enum logic [2:0] {
        pIDLE,
        pCOIN,
        pSELECT,
        pVEND,
        pRETURN_MONEY
    } vend_state_t;

    localparam logic [7:0] ST_CHAR_I   = 8'h49;
    localparam logic [7:0] ST_CHAR_W   = 8'h57;
    localparam logic [7:0] ST_CHAR_S   = 8'h53;
    localparam logic [7:0] ST_CHAR_C   = 8'h43;
    localparam logic [7:0] ST_CHAR_R   = 8'h52;
    localparam logic [7:0] ST_CHAR_UNK = 8'h2D;

`ifdef STATUS_TX_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int TX_FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int TX_FRAME_BITS = 10;
`endif

endpackage

// File: rtl/status_uart_tx_if.sv
// Status-code input and serial-line output bundle of status_uart_tx.
// master drives codes and controls, slave is the transmitter.
interface status_uart_tx_if;

    logic       tx_en;
    logic [7:0] status_display;
    logic       overflow_clr;
    logic       uart_tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output tx_en,
        output status_display,
        output overflow_clr,
        input  uart_tx,
        input  tx_busy,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  tx_en,
        input  status_display,
        input  overflow_clr,
        output uart_tx,
        output tx_busy,
        output fifo_full,
        output overflow
    );

endinterface

// File: rtl/status_tx_fifo.sv
// Synchronous FIFO queueing status codes for the UART transmitter.
// Wrap-bit pointers; a push on a full queue is taken only alongside a pop.
module status_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         wr_en;
    logic         rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/status_uart_tx.sv
// Sends each new status code LSB-first as UART 8N1 (8E1 when
// STATUS_TX_PARITY_EN is defined), queueing codes that arrive mid-frame.
module status_uart_tx
    import status_pkg::*;
#(
    parameter int CLK_DIV       = 434,
    parameter int FIFO_DEPTH    = 4,
    parameter int SUPPRESS_ZERO = 1
) (
    input logic             clk,
    input logic             rst,
    status_uart_tx_if.slave bus
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    tx_state_t     state;
    logic [7:0]    prev_code;
    logic [7:0]    sh;
    logic [7:0]    dout;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          tx_q;
    logic          busy_q;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic          empty;
    logic          full;
    logic          bit_end;
    logic          ovf_set;
`ifdef STATUS_TX_PARITY_EN
    logic          par;
`endif

    assign bit_end = (cnt == '0);
    assign push    = bus.tx_en &&
                     (bus.status_display != prev_code) &&
                     !((SUPPRESS_ZERO != 0) &&
                       (bus.status_display == 8'h00));
    assign pop     = !empty &&
                     ((state == TX_IDLE) ||
                      ((state == TX_STOP) && bit_end));
    assign ovf_set = push && full && !pop;

    assign bus.uart_tx   = tx_q;
    assign bus.tx_busy   = busy_q;
    assign bus.fifo_full = full;
    assign bus.overflow  = ovf_q;

    status_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.status_display),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= TX_IDLE;
            prev_code <= '0;
            sh        <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef STATUS_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            prev_code <= bus.status_display;
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (bus.overflow_clr) begin
                ovf_q <= 1'b0;
            end
            // every bit lasts CLK_DIV cycles; reload at each boundary
            if (state != TX_IDLE) begin
                cnt <= bit_end ? RELOAD : cnt - 1'b1;
            end
            unique case (state)
                TX_IDLE: begin
                    if (!empty) begin
                        sh     <= dout;
                        tx_q   <= 1'b0;
                        busy_q <= 1'b1;
                        cnt    <= RELOAD;
                        state  <= TX_START;
`ifdef STATUS_TX_PARITY_EN
                        par    <= ^dout;
`endif
                    end
                end
                TX_START: begin
                    if (bit_end) begin
                        tx_q    <= sh[0];
                        sh      <= sh >> 1;
                        bit_idx <= '0;
                        state   <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef STATUS_TX_PARITY_EN
                            tx_q  <= par;
                            state <= TX_PARITY;
`else
                            tx_q  <= 1'b1;
                            state <= TX_STOP;
`endif
                        end else begin
                            tx_q    <= sh[0];
                            sh      <= sh >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef STATUS_TX_PARITY_EN
                TX_PARITY: begin
                    if (bit_end) begin
                        tx_q  <= 1'b1;
                        state <= TX_STOP;
                    end
                end
`endif
                TX_STOP: begin
                    if (bit_end) begin
                        if (!empty) begin
                            sh    <= dout;
                            tx_q  <= 1'b0;
                            state <= TX_START;
`ifdef STATUS_TX_PARITY_EN
                            par   <= ^dout;
`endif
                        end else begin
                            busy_q <= 1'b0;
                            state  <= TX_IDLE;
                        end
                    end
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_status_uart_tx.sv
// Scoreboard bench for status_uart_tx: queued codes are matched against
// frames decoded cycle-by-cycle from uart_tx.
module tb_status_uart_tx;
    import status_pkg::*;

    localparam int CLK_DIV   = 4;
    localparam int NB        = TX_FRAME_BITS;
    localparam int FRAME_CYC = NB * CLK_DIV;

    logic clk = 1'b0;
    logic rst;

    status_uart_tx_if bus ();

    status_uart_tx #(
        .CLK_DIV       (CLK_DIV),
        .FIFO_DEPTH    (4),
        .SUPPRESS_ZERO (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    int         frames = 0;
    logic       in_frame = 1'b0;
    logic [7:0] sb [$];
    int         starts [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input logic [NB-1:0] b, input logic ok);
        logic [7:0] d;
        d = b[8:1];
        chk("bit_width", 32'(ok), 32'd1);
        chk("stop_bit", 32'(b[NB-1]), 32'd1);
`ifdef STATUS_TX_PARITY_EN
        chk("parity", 32'(b[9]), 32'(^d));
`endif
        chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            chk("frame_data", 32'(d), 32'(sb.pop_front()));
        end
    endtask

    // line monitor: every cycle of every bit must hold the bit value
    initial begin : mon
        logic          prev_line;
        logic [NB-1:0] bits;
        logic          ok;
        int            pos;
        prev_line = 1'b1;
        bits = '0;
        ok = 1'b1;
        pos = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame  = 1'b0;
                prev_line = 1'b1;
            end else begin
                if (!in_frame) begin
                    if (prev_line && !bus.uart_tx) begin
                        in_frame = 1'b1;
                        pos = 1;
                        bits = '0;
                        ok = 1'b1;
                        starts.push_back(cyc);
                    end
                end else begin
                    if (pos % CLK_DIV == 0)
                        bits[pos / CLK_DIV] = bus.uart_tx;
                    else if (bus.uart_tx !== bits[pos / CLK_DIV])
                        ok = 1'b0;
                    pos++;
                    if (pos == FRAME_CYC) begin
                        in_frame = 1'b0;
                        frames++;
                        check_frame(bits, ok);
                    end
                end
                prev_line = bus.uart_tx;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || bus.tx_busy || in_frame) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(t < 2000), 32'd1);
        tick(2);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("idle_line", 32'(bus.uart_tx), 32'd1);
    endtask

    initial begin
        int         f0;
        int         t;
        logic       full_seen;
        logic [7:0] codes [6];

        codes = '{ST_CHAR_I, ST_CHAR_W, ST_CHAR_S,
                  ST_CHAR_C, ST_CHAR_R, ST_CHAR_UNK};
        rst = 1'b1;
        bus.tx_en = 1'b1;
        bus.status_display = 8'h00;
        bus.overflow_clr = 1'b0;
        tick(3);
        chk("rst_uart_tx", 32'(bus.uart_tx), 32'd1);
        chk("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
        chk("rst_fifo_full", 32'(bus.fifo_full), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        rst = 1'b0;
        tick(2);

        // single frame, latency and busy length
        bus.status_display = ST_CHAR_I;
        sb.push_back(ST_CHAR_I);
        tick(1);
        chk("lat_edge_k", 32'(bus.uart_tx), 32'd1);
        tick(1);
        chk("lat_edge_k1", 32'(bus.uart_tx), 32'd0);
        chk("busy_set", 32'(bus.tx_busy), 32'd1);
        t = 1;
        while (bus.tx_busy && t < 500) begin
            tick(1);
            if (bus.tx_busy) t++;
        end
        chk("busy_cycles", 32'(t), 32'(FRAME_CYC));
        drain();

        // back-to-back frames
        starts.delete();
        bus.status_display = 8'h00;
        tick(1);
        for (int i = 0; i < 3; i++) begin
            bus.status_display = codes[i];
            sb.push_back(codes[i]);
            tick(1);
        end
        drain();
        chk("b2b_frames", 32'(starts.size()), 32'd3);
        if (starts.size() == 3) begin
            chk("b2b_gap1", 32'(starts[1] - starts[0]), 32'(FRAME_CYC));
            chk("b2b_gap2", 32'(starts[2] - starts[1]), 32'(FRAME_CYC));
        end

        // overflow: sixth code is dropped
        bus.status_display = 8'h00;
        tick(1);
        full_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.status_display = codes[i];
            if (i < 5) sb.push_back(codes[i]);
            tick(1);
            if (bus.fifo_full) full_seen = 1'b1;
        end
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("full_seen", 32'(full_seen), 32'd1);
        tick(20);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        bus.overflow_clr = 1'b1;
        tick(1);
        bus.overflow_clr = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        drain();
        chk("full_after", 32'(bus.fifo_full), 32'd0);

        // held code, suppressed zero, tx_en low
        f0 = frames;
        bus.status_display = ST_CHAR_W;
        sb.push_back(ST_CHAR_W);
        tick(100);
        drain();
        chk("hold_one_frame", 32'(frames - f0), 32'd1);
        f0 = frames;
        bus.status_display = 8'h00;
        tick(60);
        chk("zero_no_frame", 32'(frames - f0), 32'd0);
        chk("zero_idle", 32'(bus.tx_busy), 32'd0);
        bus.tx_en = 1'b0;
        bus.status_display = ST_CHAR_C;
        tick(60);
        chk("txen_no_frame", 32'(frames - f0), 32'd0);
        bus.tx_en = 1'b1;
        tick(60);
        chk("txen_re_no_frame", 32'(frames - f0), 32'd0);

        // reset mid data bit
        f0 = frames;
        bus.status_display = ST_CHAR_R;
        tick(1);
        bus.status_display = ST_CHAR_I;
        tick(1);
        bus.status_display = ST_CHAR_S;
        tick(9);
        chk("pre_rst_busy", 32'(bus.tx_busy), 32'd1);
        rst = 1'b1;
        bus.status_display = 8'h00;
        tick(1);
        chk("mid_rst_uart_tx", 32'(bus.uart_tx), 32'd1);
        chk("mid_rst_busy", 32'(bus.tx_busy), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(100);
        chk("rst_no_frames", 32'(frames - f0), 32'd0);
        chk("rst_line_idle", 32'(bus.uart_tx), 32'd1);

        // 0x43 (parity bit checked when enabled)
        bus.status_display = ST_CHAR_C;
        sb.push_back(ST_CHAR_C);
        tick(1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
